// File: rtl/multi_cycle_data_path.sv
// ---------------------------------------------------------------------------
// multi_cycle_data_path
//   Multi-cycle MIPS-subset processor core: FETCH -> DECODE -> EXEC
//   -> (MEM) -> (WB), with a single shared request/ready memory port.
//   Supports add/sub/and/or/slt, addi, lw, sw, beq and j.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   mem_req    out  memory request, held until mem_ready completes it
//   mem_we     out  1 = store, 0 = read
//   mem_addr   out  byte address of the request
//   mem_wdata  out  store data (register B)
//   mem_rdata  in   read data, sampled when mem_ready=1
//   mem_ready  in   completes the pending request
//   PC         out  current program counter
//   state      out  FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4
//   retire     out  pulse in the final cycle of each instruction
//   illegal    out  pulse when an unsupported opcode/funct reaches EXEC
// ---------------------------------------------------------------------------
module multi_cycle_data_path #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] PC,
  output logic [2:0]  state,
  output logic        retire,
  output logic        illegal
);

  localparam int IdxW = $clog2(NUM_REGS);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } stateT;

  stateT       state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] aluOut_q;
  logic [31:0] mdr_q;
  logic [31:0] regFile_q [NUM_REGS];

  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [31:0]     immExt;
  logic [IdxW-1:0] rsIdx;
  logic [IdxW-1:0] rtIdx;
  logic [IdxW-1:0] rdIdx;
  logic            rTypeOk;
  logic            legalOp;
  logic [31:0]     aluResult;
  logic [IdxW-1:0] wbIdx;
  logic [31:0]     wbData;

  // Instruction field decode and the ALU. Specifier bits above the
  // register-file size are simply not selected. Outside R-type the ALU
  // always forms A + sign-extended immediate (addi and address calc).
  always_comb begin
    opcode  = ir_q[31:26];
    funct   = ir_q[5:0];
    immExt  = {{16{ir_q[15]}}, ir_q[15:0]};
    rsIdx   = ir_q[21 +: IdxW];
    rtIdx   = ir_q[16 +: IdxW];
    rdIdx   = ir_q[11 +: IdxW];
    rTypeOk = (opcode == OpRtype) &&
              (funct inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt});
    legalOp = rTypeOk || (opcode inside {OpAddi, OpLw, OpSw, OpBeq, OpJ});

    aluResult = a_q + immExt;
    if (opcode == OpRtype) begin
      case (funct)
        FnAdd:   aluResult = a_q + b_q;
        FnSub:   aluResult = a_q - b_q;
        FnAnd:   aluResult = a_q & b_q;
        FnOr:    aluResult = a_q | b_q;
        FnSlt:   aluResult = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
        default: aluResult = '0;
      endcase
    end

    wbIdx  = (opcode == OpRtype) ? rdIdx : rtIdx;
    wbData = (opcode == OpLw) ? mdr_q : aluOut_q;
  end

  // Memory port and status outputs are decoded from registered state, so
  // address/we/wdata cannot move while a request waits for mem_ready.
  // A store retires in the cycle its ready arrives.
  always_comb begin
    mem_req   = (state_q == FETCH) || (state_q == MEM);
    mem_we    = (state_q == MEM) && (opcode == OpSw);
    mem_addr  = (state_q == MEM) ? aluOut_q : pc_q;
    mem_wdata = b_q;
    PC        = pc_q;
    state     = state_q;
    retire    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      EXEC: begin
        if (!legalOp) begin
          illegal = 1'b1;
          retire  = 1'b1;
        end else if ((opcode == OpBeq) || (opcode == OpJ)) begin
          retire = 1'b1;
        end
      end
      MEM:     retire = (opcode == OpSw) && mem_ready;
      WB:      retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  // Sequencer and all architectural state. The branch target is formed in
  // DECODE from the already-incremented PC so EXEC only has to select it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluOut_q <= '0;
      mdr_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regFile_q[i] <= '0;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (mem_ready) begin
            ir_q    <= mem_rdata;
            pc_q    <= pc_q + 32'd4;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          a_q      <= regFile_q[rsIdx];
          b_q      <= regFile_q[rtIdx];
          aluOut_q <= pc_q + {immExt[29:0], 2'b00};
          state_q  <= EXEC;
        end
        EXEC: begin
          state_q <= FETCH;
          if (legalOp) begin
            case (opcode)
              OpRtype, OpAddi: begin
                aluOut_q <= aluResult;
                state_q  <= WB;
              end
              OpLw, OpSw: begin
                aluOut_q <= aluResult;
                state_q  <= MEM;
              end
              OpBeq: begin
                if (a_q == b_q) pc_q <= aluOut_q;
              end
              OpJ: begin
                pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
              end
              default: state_q <= FETCH;
            endcase
          end
        end
        MEM: begin
          if (mem_ready) begin
            if (opcode == OpLw) begin
              mdr_q   <= mem_rdata;
              state_q <= WB;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        WB: begin
          // Register 0 is hardwired to zero, so its writes are dropped.
          if (wbIdx != '0) regFile_q[wbIdx] <= wbData;
          state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_data_path.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_data_path
//   Directed testbench for multi_cycle_data_path. A small Harvard-style
//   memory model returns instruction words during FETCH and data words
//   during MEM; the instruction store is patched between instructions to
//   steer the program through each scenario.
// ---------------------------------------------------------------------------
module tb_multi_cycle_data_path;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] PC;
  logic [2:0]  state;
  logic        retire;
  logic        illegal;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  int          storeCount;
  int          checkCount;
  int          failCount;

  multi_cycle_data_path dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .PC        (PC),
    .state     (state),
    .retire    (retire),
    .illegal   (illegal)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data accesses happen only in MEM; everything else reads the program
  assign mem_rdata = (state == 3'd3) ? dmem[mem_addr[7:2]] : imem[mem_addr[7:2]];

  // Store side of the memory model, counting completed store transfers
  always @(posedge clk) begin
    if (reset && mem_req && mem_we && mem_ready) begin
      dmem[mem_addr[7:2]] <= mem_wdata;
      storeCount          <= storeCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Set mem_ready, then advance the given number of cycles (to a negedge)
  task automatic applyStimulus(input logic readyVal, input int cycles);
    mem_ready = readyVal;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    storeCount = 0;
    reset      = 1'b0;
    mem_ready  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      imem[i] = 32'h0;
      dmem[i] = 32'h0;
    end
    imem[0] = 32'h2001_0005; // addi $1,$0,5
    imem[1] = 32'h2002_0007; // addi $2,$0,7
    imem[2] = 32'h0022_1820; // add  $3,$1,$2
    imem[3] = 32'h8C04_0000; // lw   $4,0($0)
    imem[4] = 32'h1021_FFFF; // beq  $1,$1,-1
    imem[5] = 32'hAC04_0008; // sw   $4,8($0)
    imem[6] = 32'h0041_2822; // sub  $5,$2,$1
    imem[7] = 32'h0022_302A; // slt  $6,$1,$2
    imem[8] = 32'h0800_0001; // j    0x000001
    dmem[0] = 32'hDEAD_BEEF;

    // Held in reset
    repeat (2) @(negedge clk);
    checkOutput("rst_pc", PC, 32'h0);
    checkOutput("rst_state", {29'h0, state}, 32'd0);
    checkOutput("rst_retire", {31'h0, retire}, 32'd0);
    checkOutput("rst_illegal", {31'h0, illegal}, 32'd0);

    // Release; the first fetch is requested right away
    reset = 1'b1;
    #1;
    checkOutput("first_req", {31'h0, mem_req}, 32'd1);
    checkOutput("first_addr", mem_addr, 32'h0);

    // addi, addi, add with ready tied high: retire every fourth cycle
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      checkOutput($sformatf("retire_c%0d", c), {31'h0, retire},
                  (c % 4 == 3) ? 32'd1 : 32'd0);
    end
    checkOutput("seq_pc", PC, 32'h0000_000C);
    checkOutput("r1", dut.regFile_q[1], 32'd5);
    checkOutput("r2", dut.regFile_q[2], 32'd7);
    checkOutput("r3_add", dut.regFile_q[3], 32'd12);

    // lw with ready held off for three MEM cycles
    applyStimulus(1'b1, 3);
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_ready = 1'b1;
      checkOutput($sformatf("lw_state_%0d", k), {29'h0, state}, 32'd3);
      checkOutput($sformatf("lw_addr_%0d", k), mem_addr, 32'h0);
      checkOutput($sformatf("lw_we_%0d", k), {31'h0, mem_we}, 32'd0);
      @(negedge clk);
    end
    @(negedge clk);
    checkOutput("r4_lw", dut.regFile_q[4], 32'hDEAD_BEEF);
    checkOutput("lw_pc", PC, 32'h0000_0010);
    checkOutput("lw_done_state", {29'h0, state}, 32'd0);

    // beq taken back onto itself, then patched to an untaken compare
    applyStimulus(1'b1, 2);
    checkOutput("beq_retire", {31'h0, retire}, 32'd1);
    @(negedge clk);
    checkOutput("beq_taken_pc", PC, 32'h0000_0010);
    imem[4] = 32'h1022_FFFF; // beq $1,$2,-1
    applyStimulus(1'b1, 3);
    checkOutput("beq_nt_pc", PC, 32'h0000_0014);

    // sw $4,8($0)
    applyStimulus(1'b1, 3);
    checkOutput("sw_req", {31'h0, mem_req}, 32'd1);
    checkOutput("sw_we", {31'h0, mem_we}, 32'd1);
    checkOutput("sw_addr", mem_addr, 32'h0000_0008);
    checkOutput("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    checkOutput("sw_retire", {31'h0, retire}, 32'd1);
    @(negedge clk);
    checkOutput("sw_after_state", {29'h0, state}, 32'd0);
    checkOutput("sw_mem", dmem[2], 32'hDEAD_BEEF);
    checkOutput("sw_count", storeCount, 32'd1);
    checkOutput("sw_pc", PC, 32'h0000_0018);

    // sub and slt
    applyStimulus(1'b1, 4);
    checkOutput("r5_sub", dut.regFile_q[5], 32'd2);
    applyStimulus(1'b1, 4);
    checkOutput("r6_slt", dut.regFile_q[6], 32'd1);
    checkOutput("j_fetch_pc", PC, 32'h0000_0020);

    // Jump lands at 0x04, which now holds an illegal opcode followed by
    // a lw that will be interrupted by reset
    imem[1] = 32'hFC00_0000;
    imem[2] = 32'h8C03_0004; // lw $3,4($0)
    dmem[1] = 32'h1234_5678;
    applyStimulus(1'b1, 3);
    checkOutput("j_pc", PC, 32'h0000_0004);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("illegal_c%0d", k), {31'h0, illegal},
                  (k == 2) ? 32'd1 : 32'd0);
    end
    checkOutput("illegal_pc", PC, 32'h0000_0008);

    // Reset during a stalled lw in MEM
    applyStimulus(1'b1, 3);
    checkOutput("abort_mem_state", {29'h0, state}, 32'd3);
    applyStimulus(1'b0, 1);
    checkOutput("abort_addr", mem_addr, 32'h0000_0004);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort_pc", PC, 32'h0);
    checkOutput("abort_state", {29'h0, state}, 32'd0);
    checkOutput("abort_r3", dut.regFile_q[3], 32'h0);
    checkOutput("abort_retire", {31'h0, retire}, 32'd0);
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'b1;
    #1;
    checkOutput("refetch_req", {31'h0, mem_req}, 32'd1);
    checkOutput("refetch_addr", mem_addr, 32'h0);
    @(negedge clk);
    checkOutput("refetch_state", {29'h0, state}, 32'd1);
    checkOutput("refetch_pc", PC, 32'h0000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/multi_cycle_data_path.md
MULTI_CYCLE_DATA_PATH -- requirements
Module: multi_cycle_data_path

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The module SHALL have parameter NUM_REGS, default 32, legal values 8/16/32; register specifier bits above log2(NUM_REGS) are ignored.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
REQ-005 mem_req  output  1  memory request; held high until the transfer completes.
REQ-006 mem_we  output  1  1 = store, 0 = read; valid while mem_req=1.
REQ-007 mem_addr  output  32  byte address of the request.
REQ-008 mem_wdata  output  32  store data; valid while mem_req=1 and mem_we=1.
REQ-009 mem_rdata  input  32  read data; sampled in the cycle mem_ready=1.
REQ-010 mem_ready  input  1  completes the current request when high while mem_req=1.
REQ-011 PC  output  32  current program counter.
REQ-012 state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-013 retire  output  1  one-cycle pulse in the last cycle of each instruction.
REQ-014 illegal  output  1  one-cycle pulse when an unsupported opcode or funct reaches EXEC.

Function
REQ-015 The block SHALL execute these instructions: R-type (op 000000) with funct add 100000, sub 100010, and 100100, or 100101, slt 101010; addi 001000; lw 100011; sw 101011; beq 000100; j 000010.
REQ-016 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=PC; when mem_ready=1 it latches IR<=mem_rdata, sets PC<=PC+4 and goes to DECODE; otherwise it stays in FETCH.
REQ-017 DECODE SHALL latch A<=R[rs], B<=R[rt], ALUOut<=PC+(sign_ext(imm16)<<2), then go to EXEC.
REQ-018 EXEC SHALL act on the opcode as follows:
- R-type, addi: ALUOut<=result, then WB.
- lw, sw: ALUOut<=A+sign_ext(imm16), then MEM.
- beq: if A==B then PC<=ALUOut; then FETCH with retire=1.
- j: PC<={PC[31:28],target26,2'b00}; then FETCH with retire=1.
- Illegal: illegal=1, retire=1, no state change other than the PC+4 already done, then FETCH.
REQ-019 MEM SHALL drive mem_req=1, mem_addr=ALUOut, mem_we=1 for sw with mem_wdata=B; it waits for mem_ready, then:
- sw: go to FETCH with retire=1.
- lw: latch MDR<=mem_rdata, then WB.
REQ-020 WB SHALL write ALUOut (R-type to rd, addi to rt) or MDR (lw to rt), assert retire=1, then go to FETCH.
REQ-021 Register 0 SHALL always read 0; writes to it are discarded.
REQ-022 Arithmetic SHALL be 32-bit wrap-around with no overflow trap; slt is a signed compare producing 1 or 0.
REQ-023 mem_addr, mem_we and mem_wdata SHALL stay stable while mem_req=1 and mem_ready=0.
REQ-024 mem_ready SHALL be ignored when mem_req=0.
REQ-025 Minimum latency SHALL be: beq/j/illegal 3 cycles, R-type/addi/sw 4, lw 5; each mem_ready=0 cycle adds one cycle.
REQ-026 mem_req SHALL be 0 in DECODE, EXEC and WB.

Reset
REQ-027 While reset=0, the block SHALL hold: PC=RESET_PC, state=FETCH, IR/A/B/ALUOut/MDR=0, all registers=0, retire=0, illegal=0.
REQ-028 Asserting reset during a pending memory wait SHALL abort the transfer, with no register write and no PC update.
REQ-029 The first fetch SHALL be issued (mem_req=1, mem_addr=RESET_PC) in the first cycle after reset deasserts.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- mem_ready tied 1; addi $1,$0,5 then addi $2,$0,7 then add $3,$1,$2 -> R3=12, retire every 4 cycles, PC=0x0C.
- lw $4,0($0) with read data 0xDEADBEEF and mem_ready delayed 3 cycles in MEM -> mem_addr held at 0 throughout, R4=0xDEADBEEF after 8 cycles.
- sw $4,8($0) -> mem_req=1, mem_we=1, mem_addr=0x08, mem_wdata=R4 for exactly one ready cycle.
- beq $1,$1,-1 at PC=0x10 -> PC=0x10 after 3 cycles; beq with unequal operands -> PC=0x14.
- j 0x000001 at PC=0x20 -> PC=0x04; opcode 111111 -> illegal pulses once, PC advances by 4.
- reset=0 asserted mid-MEM of a lw -> target register unchanged, PC=RESET_PC, state=0.
